// File: rtl/usb_rx_pkt_ctrl_if.sv
// Byte-stream inputs from the byte assembler and packet-status outputs of the
// USB full-speed receive packet controller.
interface usb_rx_pkt_ctrl_if #(
  parameter int MAX_PAYLOAD = 64
) ();
  localparam int CW = $clog2(MAX_PAYLOAD + 1);

  logic          edge_start;
  logic          eop;
  logic          byte_valid;
  logic [7:0]    rcv_byte;
  logic          crc5_ok;
  logic          crc16_ok;
  logic [6:0]    dev_addr;

  logic          receiving;
  logic [2:0]    rx_packet;
  logic          store_rx_packet;
  logic          w_enable_buffer;
  logic [7:0]    rx_data;
  logic [3:0]    endpoint;
  logic [CW-1:0] byte_count;
  logic          r_error;
  logic          packet_done;
  logic          crc_clear;
  logic          timer_clear;

  modport master (
    output edge_start, eop, byte_valid, rcv_byte, crc5_ok, crc16_ok, dev_addr,
    input  receiving, rx_packet, store_rx_packet, w_enable_buffer, rx_data,
           endpoint, byte_count, r_error, packet_done, crc_clear, timer_clear
  );

  modport slave (
    input  edge_start, eop, byte_valid, rcv_byte, crc5_ok, crc16_ok, dev_addr,
    output receiving, rx_packet, store_rx_packet, w_enable_buffer, rx_data,
           endpoint, byte_count, r_error, packet_done, crc_clear, timer_clear
  );
endinterface

// File: rtl/usb_rx_pkt_ctrl.sv
// USB full-speed receive packet controller: PID/address checks, CRC verdict gating,
// payload length limit and a 2-byte delay line that keeps CRC16 out of the buffer.
module usb_rx_pkt_ctrl #(
  parameter int MAX_PAYLOAD = 64,
  parameter bit CHECK_CRC   = 1'b1,
  parameter bit CHECK_ADDR  = 1'b1
) (
  input logic              clk,
  input logic              n_rst,
  usb_rx_pkt_ctrl_if.slave bus
);
  localparam int CW = $clog2(MAX_PAYLOAD + 1);

  typedef enum logic [2:0] {IDLE, SYNC, PID, TOKEN, DATA, HSHK, DONE, ERROR} state_t;

  localparam logic [2:0] PKT_IDLE = 3'd0;
  localparam logic [2:0] PKT_IN   = 3'd1;
  localparam logic [2:0] PKT_OUT  = 3'd2;
  localparam logic [2:0] PKT_DATA = 3'd3;
  localparam logic [2:0] PKT_ACK  = 3'd4;
  localparam logic [2:0] PKT_NAK  = 3'd5;
  localparam logic [2:0] PKT_ERR  = 3'd6;

  state_t     state_reg;
  logic [6:0] addr_reg;
  logic [3:0] ep_reg;
  logic [1:0] tok_cnt_reg;
  logic [7:0] dly_new_reg;
  logic [7:0] dly_old_reg;
  logic [1:0] dly_cnt_reg;

  logic [3:0] pid;
  logic       pid_ok;
  logic       at_max;
  logic       ev_err;
  logic       ev_done;
  logic       ev_drop;
  logic       ev_write;

  assign pid    = bus.rcv_byte[3:0];
  assign pid_ok = (bus.rcv_byte[7:4] == ~pid) &&
                  (pid inside {4'b0001, 4'b1001, 4'b0011, 4'b1011, 4'b0010, 4'b1010});
  assign at_max = (bus.byte_count == CW'(MAX_PAYLOAD));

  // Per-state verdicts; eop always takes priority over a coincident byte.
  always_comb begin
    ev_err   = 1'b0;
    ev_done  = 1'b0;
    ev_drop  = 1'b0;
    ev_write = 1'b0;
    case (state_reg)
      SYNC:  ev_err = bus.eop || (bus.byte_valid && bus.rcv_byte != 8'h80);
      PID:   ev_err = bus.eop || (bus.byte_valid && !pid_ok);
      TOKEN: begin
        if (bus.eop) begin
          if (tok_cnt_reg != 2'd2 || (CHECK_CRC && !bus.crc5_ok)) ev_err = 1'b1;
          else if (CHECK_ADDR && bus.dev_addr != addr_reg)     ev_drop = 1'b1;
          else                                                 ev_done = 1'b1;
        end else if (bus.byte_valid && tok_cnt_reg == 2'd2) begin
          ev_err = 1'b1;
        end
      end
      DATA: begin
        if (bus.eop) begin
          if (dly_cnt_reg != 2'd2 || (CHECK_CRC && !bus.crc16_ok)) ev_err = 1'b1;
          else                                                     ev_done = 1'b1;
        end else if (bus.byte_valid && dly_cnt_reg == 2'd2) begin
          if (at_max) ev_err   = 1'b1;
          else        ev_write = 1'b1;
        end
      end
      HSHK: begin
        if (bus.eop)             ev_done = 1'b1;
        else if (bus.byte_valid) ev_err  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg           <= IDLE;
      addr_reg            <= '0;
      ep_reg              <= '0;
      tok_cnt_reg         <= '0;
      dly_new_reg         <= '0;
      dly_old_reg         <= '0;
      dly_cnt_reg         <= '0;
      bus.receiving       <= 1'b0;
      bus.rx_packet       <= PKT_IDLE;
      bus.store_rx_packet <= 1'b0;
      bus.w_enable_buffer <= 1'b0;
      bus.rx_data         <= '0;
      bus.endpoint        <= '0;
      bus.byte_count      <= '0;
      bus.r_error         <= 1'b0;
      bus.packet_done     <= 1'b0;
      bus.crc_clear       <= 1'b0;
      bus.timer_clear     <= 1'b0;
    end else begin
      bus.store_rx_packet <= 1'b0;
      bus.w_enable_buffer <= 1'b0;
      bus.crc_clear       <= 1'b0;
      if (ev_err) begin
        state_reg     <= ERROR;
        bus.receiving <= 1'b0;
        bus.r_error   <= 1'b1;
        bus.rx_packet <= PKT_ERR;
      end else if (ev_done) begin
        state_reg           <= DONE;
        bus.receiving       <= 1'b0;
        bus.store_rx_packet <= 1'b1;
        bus.packet_done     <= 1'b1;
        bus.timer_clear     <= 1'b1;
        if (state_reg == TOKEN) bus.endpoint <= ep_reg;
      end else if (ev_drop) begin
        state_reg     <= IDLE;
        bus.receiving <= 1'b0;
        bus.rx_packet <= PKT_IDLE;
      end else begin
        case (state_reg)
          IDLE, DONE, ERROR: begin
            if (bus.edge_start && !(state_reg == DONE && bus.eop)) begin
              state_reg       <= SYNC;
              bus.receiving   <= 1'b1;
              bus.crc_clear   <= 1'b1;
              bus.r_error     <= 1'b0;
              bus.packet_done <= 1'b0;
              bus.timer_clear <= 1'b0;
              bus.byte_count  <= '0;
              dly_cnt_reg     <= '0;
              dly_new_reg     <= '0;
              dly_old_reg     <= '0;
            end
          end
          SYNC: if (bus.byte_valid) state_reg <= PID;
          PID: begin
            if (bus.byte_valid) begin
              tok_cnt_reg <= '0;
              case (pid)
                4'b0001: begin state_reg <= TOKEN; bus.rx_packet <= PKT_OUT;  end
                4'b1001: begin state_reg <= TOKEN; bus.rx_packet <= PKT_IN;   end
                4'b0011,
                4'b1011: begin state_reg <= DATA;  bus.rx_packet <= PKT_DATA; end
                4'b0010: begin state_reg <= HSHK;  bus.rx_packet <= PKT_ACK;  end
                4'b1010: begin state_reg <= HSHK;  bus.rx_packet <= PKT_NAK;  end
                default: ;
              endcase
            end
          end
          TOKEN: begin
            if (bus.byte_valid) begin
              if (tok_cnt_reg == 2'd0) begin
                addr_reg  <= bus.rcv_byte[6:0];
                ep_reg[0] <= bus.rcv_byte[7];
              end else begin
                ep_reg[3:1] <= bus.rcv_byte[2:0];
              end
              tok_cnt_reg <= tok_cnt_reg + 2'd1;
            end
          end
          DATA: begin
            // The two newest bytes are held back; they become the CRC16 if eop follows.
            if (bus.byte_valid) begin
              dly_old_reg <= dly_new_reg;
              dly_new_reg <= bus.rcv_byte;
              if (dly_cnt_reg != 2'd2) dly_cnt_reg <= dly_cnt_reg + 2'd1;
              if (ev_write) begin
                bus.rx_data         <= dly_old_reg;
                bus.w_enable_buffer <= 1'b1;
                bus.byte_count      <= bus.byte_count + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Randomized packet-level check of usb_rx_pkt_ctrl against a queue-based model,
// plus directed packets with hand-computed expectations.
module tb_usb_rx_pkt_ctrl;
  localparam int MAXP = 4;
  localparam int CW   = $clog2(MAXP + 1);
  localparam int VW   = 22 + CW;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  usb_rx_pkt_ctrl_if #(.MAX_PAYLOAD(MAXP)) bus ();

  usb_rx_pkt_ctrl #(
    .MAX_PAYLOAD(MAXP),
    .CHECK_CRC  (1'b1),
    .CHECK_ADDR (1'b1)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 receiving, 2 done, 3 error; bytes seen since SYNC.
  int              m_phase;
  byte unsigned    m_q[$];
  logic [2:0]      e_pkt;
  logic            e_store;
  logic            e_wen;
  logic [7:0]      e_data;
  logic [3:0]      e_ep;
  int              e_bc;
  logic            e_crc_clear;

  bit              chk_en = 1'b0;
  int              n_store = 0;
  byte unsigned    wr_log[$];

  function automatic logic [VW-1:0] act_vec();
    return {bus.receiving, bus.rx_packet, bus.store_rx_packet, bus.w_enable_buffer,
            bus.rx_data, bus.endpoint, bus.byte_count, bus.r_error, bus.packet_done,
            bus.crc_clear, bus.timer_clear};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [CW-1:0] bc;
    bc = e_bc[CW-1:0];
    return {(m_phase == 1), e_pkt, e_store, e_wen, e_data, e_ep, bc,
            (m_phase == 3), (m_phase == 2), e_crc_clear, (m_phase == 2)};
  endfunction

  always @(posedge clk) begin
    #1;
    if (bus.store_rx_packet === 1'b1) n_store++;
    if (bus.w_enable_buffer === 1'b1) wr_log.push_back(bus.rx_data);
    if (chk_en) begin
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL outputs t=%0t got=%h want=%h (rcv,pkt,st,wen,data,ep,bc,err,done,crcclr,tclr)",
                 $time, act_vec(), exp_vec());
      end
    end
  end

  task automatic lit(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_q.delete();
    e_pkt = 0; e_store = 0; e_wen = 0; e_data = 0; e_ep = 0; e_bc = 0; e_crc_clear = 0;
  endtask

  task automatic m_fail();
    m_phase = 3; e_pkt = 3'd6;
  endtask

  task automatic m_finish();
    m_phase = 2; e_store = 1'b1;
  endtask

  // Expected outputs after the coming clock edge, derived from the byte list of the packet.
  task automatic model_step(input bit es, input bit eop, input bit bv, input logic [7:0] b,
                            input bit c5, input bit c16, input logic [6:0] da);
    int n;
    logic [3:0] pid;
    e_store = 0; e_wen = 0; e_crc_clear = 0;
    if (m_phase != 1) begin
      if (es && !(m_phase == 2 && eop)) begin
        m_phase = 1; m_q.delete(); e_crc_clear = 1; e_bc = 0;
      end
    end else if (eop) begin
      n = m_q.size();
      if (n < 2) m_fail();
      else begin
        pid = m_q[1][3:0];
        if (pid inside {4'd1, 4'd9}) begin
          if (n != 4 || !c5)            m_fail();
          else if (m_q[2][6:0] != da) begin m_phase = 0; e_pkt = 0; end
          else begin e_ep = {m_q[3][2:0], m_q[2][7]}; m_finish(); end
        end else if (pid inside {4'd3, 4'd11}) begin
          if (n < 4 || !c16) m_fail(); else m_finish();
        end else m_finish();
      end
    end else if (bv) begin
      m_q.push_back(b);
      n = m_q.size();
      if (n == 1) begin
        if (b != 8'h80) m_fail();
      end else if (n == 2) begin
        pid = b[3:0];
        if (b[7:4] != ~pid) m_fail();
        else case (pid)
          4'd1:        e_pkt = 3'd2;
          4'd9:        e_pkt = 3'd1;
          4'd3, 4'd11: e_pkt = 3'd3;
          4'd2:        e_pkt = 3'd4;
          4'd10:       e_pkt = 3'd5;
          default:     m_fail();
        endcase
      end else begin
        pid = m_q[1][3:0];
        if (pid inside {4'd1, 4'd9}) begin
          if (n > 4) m_fail();
        end else if (pid inside {4'd3, 4'd11}) begin
          if (n >= 5) begin
            if (n - 4 > MAXP) m_fail();
            else begin e_wen = 1; e_data = m_q[n-3]; e_bc = n - 4; end
          end
        end else m_fail();
      end
    end
  endtask

  task automatic cyc(input bit es, input bit eop, input bit bv, input logic [7:0] b);
    @(negedge clk);
    bus.edge_start = es; bus.eop = eop; bus.byte_valid = bv; bus.rcv_byte = b;
    if (n_rst) model_step(es, eop, bv, b, bus.crc5_ok, bus.crc16_ok, bus.dev_addr);
  endtask

  task automatic send_pkt(input byte unsigned pb[$], input bit c5, input bit c16,
                          input int gap, input bit eop_bv);
    cyc(1, 0, 0, 8'h00);
    foreach (pb[i]) begin
      repeat ($urandom_range(gap, 0)) cyc(0, 0, 0, 8'h00);
      cyc(0, 0, 1, pb[i]);
    end
    bus.crc5_ok = c5; bus.crc16_ok = c16;
    cyc(0, 1, eop_bv, 8'($urandom));
    cyc(0, 0, 0, 8'h00);
    $display("pkt len=%0d pid=%02h c5=%0d c16=%0d addr=%0d -> rx_packet=%0d err=%0d done=%0d bc=%0d",
             pb.size(), (pb.size() > 1) ? pb[1] : 8'h00, c5, c16, bus.dev_addr,
             bus.rx_packet, bus.r_error, bus.packet_done, bus.byte_count);
  endtask

  initial begin
    byte unsigned pb[$];
    logic [3:0] pid;
    int kind;
    int nb;
    bus.edge_start = 0; bus.eop = 0; bus.byte_valid = 0; bus.rcv_byte = 0;
    bus.crc5_ok = 1; bus.crc16_ok = 1; bus.dev_addr = 7'd5;
    m_reset();
    cyc(0, 0, 0, 8'h00);
    chk_en = 1'b1;
    repeat (2) cyc(0, 0, 0, 8'h00);
    lit("reset_rx_packet", bus.rx_packet, 0);
    lit("reset_receiving", bus.receiving, 0);
    lit("reset_r_error", bus.r_error, 0);
    n_rst = 1'b1;
    cyc(0, 0, 0, 8'h00);

    // OUT token addr 5 ep 1 to our address
    n_store = 0;
    send_pkt('{8'h80, 8'hE1, 8'h85, 8'hC8}, 1, 1, 0, 0);
    lit("out_store", n_store, 1);
    lit("out_rx_packet", bus.rx_packet, 2);
    lit("out_endpoint", bus.endpoint, 1);
    lit("out_done", bus.packet_done, 1);
    lit("model_out_ep", e_ep, 1);

    // Same token, foreign address: silently dropped
    bus.dev_addr = 7'd6; n_store = 0;
    send_pkt('{8'h80, 8'hE1, 8'h85, 8'hC8}, 1, 1, 0, 0);
    lit("drop_store", n_store, 0);
    lit("drop_rx_packet", bus.rx_packet, 0);
    lit("drop_r_error", bus.r_error, 0);
    lit("drop_receiving", bus.receiving, 0);

    // DATA0 with 3 payload bytes
    n_store = 0; wr_log.delete();
    send_pkt('{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33, 8'hAA, 8'hBB}, 1, 1, 0, 0);
    lit("data_writes", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      lit("data_w0", wr_log[0], 8'h11);
      lit("data_w1", wr_log[1], 8'h22);
      lit("data_w2", wr_log[2], 8'h33);
    end
    lit("data_byte_count", bus.byte_count, 3);
    lit("data_rx_packet", bus.rx_packet, 3);
    lit("data_store", n_store, 1);

    // 5 payload bytes against a limit of 4
    wr_log.delete(); n_store = 0;
    send_pkt('{8'h80, 8'h4B, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hAA, 8'hBB}, 1, 1, 0, 0);
    lit("ovf_writes", wr_log.size(), 4);
    lit("ovf_r_error", bus.r_error, 1);
    lit("ovf_byte_count", bus.byte_count, 4);
    lit("ovf_store", n_store, 0);

    // Bad PID complement, then recovery via edge_start
    send_pkt('{8'h80, 8'h33}, 1, 1, 0, 0);
    lit("badpid_rx_packet", bus.rx_packet, 6);
    lit("badpid_r_error", bus.r_error, 1);
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    lit("recover_r_error", bus.r_error, 0);
    lit("recover_receiving", bus.receiving, 1);
    lit("recover_rx_packet", bus.rx_packet, 6);
    cyc(0, 1, 0, 8'h00);

    // ACK, then edge_start coinciding with eop in DONE is ignored
    n_store = 0;
    send_pkt('{8'h80, 8'hD2}, 0, 0, 0, 0);
    lit("ack_store", n_store, 1);
    lit("ack_rx_packet", bus.rx_packet, 4);
    cyc(1, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    lit("done_hold", bus.packet_done, 1);

    // Reset in the middle of a DATA packet
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h80); cyc(0, 0, 1, 8'hC3); cyc(0, 0, 1, 8'h11);
    cyc(0, 0, 1, 8'h22); cyc(0, 0, 1, 8'h33);
    n_rst = 1'b0;
    bus.edge_start = 0; bus.eop = 0; bus.byte_valid = 0;
    m_reset();
    #1;
    lit("rst_wen", bus.w_enable_buffer, 0);
    lit("rst_byte_count", bus.byte_count, 0);
    lit("rst_receiving", bus.receiving, 0);
    lit("rst_rx_packet", bus.rx_packet, 0);
    cyc(0, 0, 0, 8'h00); cyc(0, 0, 0, 8'h00);
    n_rst = 1'b1;
    cyc(0, 0, 0, 8'h00);

    // Randomized packets
    for (int k = 0; k < 300; k++) begin
      pb.delete();
      bus.dev_addr = 7'($urandom_range(6, 5));
      kind = $urandom_range(4, 0);
      pb.push_back(($urandom_range(15, 0) == 0) ? 8'($urandom) : 8'h80);
      case (kind)
        0:       pid = ($urandom_range(1, 0) != 0) ? 4'd1 : 4'd9;
        1:       pid = ($urandom_range(1, 0) != 0) ? 4'd3 : 4'd11;
        2:       pid = ($urandom_range(1, 0) != 0) ? 4'd2 : 4'd10;
        default: pid = 4'($urandom);
      endcase
      if ($urandom_range(11, 0) == 0) pb.push_back({pid ^ 4'h4, pid});
      else                            pb.push_back({~pid, pid});
      case (kind)
        0: begin
          nb = ($urandom_range(5, 0) == 0) ? $urandom_range(3, 0) : 2;
          for (int j = 0; j < nb; j++)
            pb.push_back((j == 0) ? {1'($urandom), 7'($urandom_range(6, 5))} : 8'($urandom));
        end
        1: begin
          nb = $urandom_range(MAXP + 4, 0);
          for (int j = 0; j < nb; j++) pb.push_back(8'($urandom));
        end
        2: if ($urandom_range(5, 0) == 0) pb.push_back(8'($urandom));
        3: begin
          nb = $urandom_range(3, 0);
          for (int j = 0; j < nb; j++) pb.push_back(8'($urandom));
        end
        default: while (pb.size() > $urandom_range(1, 0)) void'(pb.pop_back());
      endcase
      send_pkt(pb, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, 2,
               $urandom_range(7, 0) == 0);
      if ($urandom_range(7, 0) == 0) cyc(1, 1, 0, 8'h00);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
